// File: rtl/latency_meas_pkg.sv
// rtl/latency_meas_pkg.sv - shared widths and read-FSM encoding for the echo latency block
package latency_meas_pkg;

   localparam int CNT_W  = 40;
   localparam int ADDR_W = 13;
   localparam int SUM_W  = 56;
   localparam int NUM_W  = 32;
   localparam int DEPTH  = 2 ** ADDR_W;

   // outstanding value at which the timestamp ring is full
   localparam logic [ADDR_W:0] OUT_FULL = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT1 = 2'd2,
      WAIT2 = 2'd3
   } rd_state_t;

endpackage

// File: rtl/latency_stats_accum.sv
// rtl/latency_stats_accum.sv - last/min/max/sum/count statistics over measured round-trip latencies
module latency_stats_accum
   import latency_meas_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             lat_valid,
   input  logic [CNT_W-1:0] lat,
   output logic             result_valid,
   output logic [CNT_W-1:0] last_latency,
   output logic [CNT_W-1:0] min_latency,
   output logic [CNT_W-1:0] max_latency,
   output logic [SUM_W-1:0] sum_latency,
   output logic [NUM_W-1:0] num_samples
);

   // one extra bit catches the carry that signals saturation
   logic [SUM_W:0] sum_ext;

   assign sum_ext = {1'b0, sum_latency} + (SUM_W + 1)'(lat);

   always_ff @(posedge clk) begin
      if (clr) begin
         result_valid <= 1'b0;
         last_latency <= '0;
         min_latency  <= '1;
         max_latency  <= '0;
         sum_latency  <= '0;
         num_samples  <= '0;
      end else begin
         result_valid <= lat_valid;
         if (lat_valid) begin
            last_latency <= lat;
            if (lat < min_latency) begin
               min_latency <= lat;
            end
            if (lat > max_latency) begin
               max_latency <= lat;
            end
            sum_latency <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            if (num_samples != '1) begin
               num_samples <= num_samples + NUM_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/latency_meas_ctrl.sv
// rtl/latency_meas_ctrl.sv - sequences the echo timestamp BRAM and derives round-trip latency statistics
module latency_meas_ctrl
   import latency_meas_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              latency_reset_signal,
   input  logic [CNT_W-1:0]  latency_counter,
   input  logic              tx_send,
   input  logic              rx_recv,
   output logic              bram_wea,
   output logic [ADDR_W-1:0] bram_wr_addr,
   output logic [CNT_W-1:0]  bram_wr_data,
   output logic              bram_reb,
   output logic              bram_rstb,
   output logic [ADDR_W-1:0] bram_rd_addr,
   input  logic [CNT_W-1:0]  bram_rd_data,
   output logic              rx_busy,
   output logic              result_valid,
   output logic [CNT_W-1:0]  last_latency,
   output logic [CNT_W-1:0]  min_latency,
   output logic [CNT_W-1:0]  max_latency,
   output logic [SUM_W-1:0]  sum_latency,
   output logic [NUM_W-1:0]  num_samples,
   output logic [ADDR_W:0]   outstanding,
   output logic              err_full,
   output logic              err_empty,
   output logic              err_overrun
);

   logic              clr;
   rd_state_t         state;
   rd_state_t         state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  rx_ts;
   logic [CNT_W-1:0]  lat;
   logic              tx_ok;
   logic              rx_accept;
   logic              rx_empty;
   logic              rx_overrun;
   logic              rd_dec;
   logic              lat_valid;

   assign clr          = rst | latency_reset_signal;
   assign bram_rstb    = latency_reset_signal;
   assign bram_rd_addr = rd_ptr;
   assign tx_ok        = tx_send && (outstanding != OUT_FULL);
   assign rd_dec       = (state == ISSUE);
   // modular subtraction absorbs a timestamp counter wrap between send and return
   assign lat          = rx_ts - bram_rd_data;

   always_comb begin
      state_nxt  = state;
      rx_accept  = 1'b0;
      rx_empty   = 1'b0;
      rx_overrun = 1'b0;
      bram_reb   = 1'b0;
      rx_busy    = 1'b0;
      lat_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (rx_recv) begin
               if (outstanding != '0) begin
                  rx_accept = 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  rx_empty = 1'b1;
               end
            end
         end
         ISSUE: begin
            bram_reb   = 1'b1;
            rx_busy    = 1'b1;
            rx_overrun = rx_recv;
            state_nxt  = WAIT1;
         end
         WAIT1: begin
            rx_busy    = 1'b1;
            rx_overrun = rx_recv;
            state_nxt  = WAIT2;
         end
         WAIT2: begin
            rx_busy    = 1'b1;
            rx_overrun = rx_recv;
            lat_valid  = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         rx_ts        <= '0;
         outstanding  <= '0;
         bram_wea     <= 1'b0;
         bram_wr_addr <= '0;
         bram_wr_data <= '0;
         err_full     <= 1'b0;
         err_empty    <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         bram_wea <= tx_ok;
         if (tx_ok) begin
            bram_wr_addr <= wr_ptr;
            bram_wr_data <= latency_counter;
            wr_ptr       <= wr_ptr + ADDR_W'(1);
         end
         if (rx_accept) begin
            rx_ts <= latency_counter;
         end
         if (rd_dec) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         // a read leaves the count while it is being issued, a send joins it the next cycle
         outstanding <= outstanding + (ADDR_W + 1)'(tx_ok) - (ADDR_W + 1)'(rd_dec);
         err_full    <= err_full    | (tx_send & ~tx_ok);
         err_empty   <= err_empty   | rx_empty;
         err_overrun <= err_overrun | rx_overrun;
      end
   end

   latency_stats_accum u_stats (
      .clk          (clk),
      .clr          (clr),
      .lat_valid    (lat_valid),
      .lat          (lat),
      .result_valid (result_valid),
      .last_latency (last_latency),
      .min_latency  (min_latency),
      .max_latency  (max_latency),
      .sum_latency  (sum_latency),
      .num_samples  (num_samples)
   );

endmodule

// File: tb/tb_latency_meas_ctrl.sv
// tb/tb_latency_meas_ctrl.sv - directed self-checking bench with a transaction-level latency model
module tb_latency_meas_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        latency_reset_signal = 1'b0;
   logic [39:0] latency_counter = '0;
   logic        tx_send = 1'b0;
   logic        rx_recv = 1'b0;
   logic        bram_wea;
   logic [12:0] bram_wr_addr;
   logic [39:0] bram_wr_data;
   logic        bram_reb;
   logic        bram_rstb;
   logic [12:0] bram_rd_addr;
   logic [39:0] bram_rd_data;
   logic        rx_busy;
   logic        result_valid;
   logic [39:0] last_latency;
   logic [39:0] min_latency;
   logic [39:0] max_latency;
   logic [55:0] sum_latency;
   logic [31:0] num_samples;
   logic [13:0] outstanding;
   logic        err_full;
   logic        err_empty;
   logic        err_overrun;

   latency_meas_ctrl dut (
      .clk                  (clk),
      .rst                  (rst),
      .latency_reset_signal (latency_reset_signal),
      .latency_counter      (latency_counter),
      .tx_send              (tx_send),
      .rx_recv              (rx_recv),
      .bram_wea             (bram_wea),
      .bram_wr_addr         (bram_wr_addr),
      .bram_wr_data         (bram_wr_data),
      .bram_reb             (bram_reb),
      .bram_rstb            (bram_rstb),
      .bram_rd_addr         (bram_rd_addr),
      .bram_rd_data         (bram_rd_data),
      .rx_busy              (rx_busy),
      .result_valid         (result_valid),
      .last_latency         (last_latency),
      .min_latency          (min_latency),
      .max_latency          (max_latency),
      .sum_latency          (sum_latency),
      .num_samples          (num_samples),
      .outstanding          (outstanding),
      .err_full             (err_full),
      .err_empty            (err_empty),
      .err_overrun          (err_overrun)
   );

   always #2 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM with a two-cycle registered read
   logic [39:0] mem [0:8191];
   logic [39:0] q1 = '0;
   logic [39:0] q2 = '0;
   assign bram_rd_data = q2;
   always @(posedge clk) begin
      if (bram_rstb) begin
         q1 <= '0;
         q2 <= '0;
      end else begin
         if (bram_wea) mem[bram_wr_addr] <= bram_wr_data;
         if (bram_reb) q1 <= mem[bram_rd_addr];
         q2 <= q1;
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
   endtask

   typedef struct packed {
      logic [12:0] addr;
      logic [39:0] data;
   } wr_t;

   typedef struct packed {
      logic        rv;
      logic [39:0] last;
      logic [39:0] mn;
      logic [39:0] mx;
      logic [55:0] sum;
      logic [31:0] num;
   } st_t;

   // expectations keyed by the cycle in which the DUT must show them
   wr_t         exp_wr   [int];
   logic [12:0] exp_rd   [int];
   bit          exp_busy [int];
   logic [13:0] exp_out  [int];
   logic [2:0]  exp_err  [int];
   st_t         stat_evt [int];

   logic [39:0] ts_q [$];
   logic [13:0] m_out = '0;
   logic [12:0] m_wp = '0;
   logic [12:0] m_rp = '0;
   logic [2:0]  m_err = '0;
   int          m_free = 0;
   bit          m_issue = 0;
   st_t         m_st;

   task automatic model_step();
      int          t = cyc;
      logic [13:0] out_now;
      bit          inc;
      bit          nxt_issue;
      logic [39:0] lat;
      logic [56:0] s;
      if (rst || latency_reset_signal) begin
         for (int k = 1; k <= 4; k++) begin
            exp_wr.delete(t + k);
            exp_rd.delete(t + k);
            exp_busy.delete(t + k);
            stat_evt.delete(t + k);
         end
         ts_q.delete();
         m_out = '0; m_wp = '0; m_rp = '0; m_err = '0; m_free = 0; m_issue = 0;
         m_st.rv = 1'b0; m_st.last = '0; m_st.mn = {40{1'b1}}; m_st.mx = '0;
         m_st.sum = '0; m_st.num = '0;
         stat_evt[t + 1] = m_st;
      end else begin
         out_now = m_out;
         inc = 0;
         nxt_issue = 0;
         if (tx_send) begin
            if (out_now < 14'd8192) begin
               exp_wr[t + 1] = '{addr: m_wp, data: latency_counter};
               ts_q.push_back(latency_counter);
               m_wp = m_wp + 13'd1;
               inc = 1;
            end else begin
               m_err[2] = 1'b1;
            end
         end
         if (rx_recv) begin
            if (t < m_free) begin
               m_err[0] = 1'b1;
            end else if (out_now == 0) begin
               m_err[1] = 1'b1;
            end else begin
               exp_rd[t + 1] = m_rp;
               m_rp = m_rp + 13'd1;
               lat = latency_counter - ts_q.pop_front();
               for (int k = 1; k <= 3; k++) exp_busy[t + k] = 1;
               m_free = t + 4;
               nxt_issue = 1;
               m_st.last = lat;
               if (lat < m_st.mn) m_st.mn = lat;
               if (lat > m_st.mx) m_st.mx = lat;
               s = m_st.sum + lat;
               m_st.sum = s[56] ? {56{1'b1}} : s[55:0];
               if (m_st.num != 32'hFFFF_FFFF) m_st.num = m_st.num + 32'd1;
               m_st.rv = 1'b1;
               stat_evt[t + 4] = m_st;
               m_st.rv = 1'b0;
            end
         end
         m_out = out_now + 14'(inc) - 14'(m_issue);
         m_issue = nxt_issue;
      end
      exp_out[t + 1] = m_out;
      exp_err[t + 1] = m_err;
   endtask

   int  cmp_start = 1 << 30;
   int  rv_cnt = 0;
   st_t cur;
   bit  e_wr;
   bit  e_rd;
   bit  e_rv;

   always @(negedge clk) begin
      if (cyc >= cmp_start) begin
         e_wr = exp_wr.exists(cyc);
         check("bram_wea", bram_wea, e_wr);
         if (e_wr) begin
            check("bram_wr_addr", bram_wr_addr, exp_wr[cyc].addr);
            check("bram_wr_data", bram_wr_data, exp_wr[cyc].data);
         end
         e_rd = exp_rd.exists(cyc);
         check("bram_reb", bram_reb, e_rd);
         if (e_rd) check("bram_rd_addr", bram_rd_addr, exp_rd[cyc]);
         check("rx_busy", rx_busy, exp_busy.exists(cyc));
         check("bram_rstb", bram_rstb, latency_reset_signal);
         e_rv = 0;
         if (stat_evt.exists(cyc)) begin
            cur = stat_evt[cyc];
            e_rv = cur.rv;
         end
         check("result_valid", result_valid, e_rv);
         check("last_latency", last_latency, cur.last);
         check("min_latency", min_latency, cur.mn);
         check("max_latency", max_latency, cur.mx);
         check("sum_latency", sum_latency, cur.sum);
         check("num_samples", num_samples, cur.num);
         if (exp_out.exists(cyc)) check("outstanding", outstanding, exp_out[cyc]);
         if (exp_err.exists(cyc)) check("err_flags", {err_full, err_empty, err_overrun}, exp_err[cyc]);
         if (result_valid === 1'b1) rv_cnt++;
      end
   end

   logic [39:0] cnt = '0;

   task automatic step(input bit tx, input bit rx);
      tx_send = tx;
      rx_recv = rx;
      latency_counter = cnt;
      model_step();
      @(posedge clk);
      #1;
      cnt = cnt + 40'd1;
   endtask

   task automatic idle_until(input logic [39:0] v);
      int n = 0;
      while (cnt != v && n < 2000) begin
         step(0, 0);
         n++;
      end
      check("idle_until_reach", cnt, v);
   endtask

   task automatic echo(input logic [39:0] ts, input logic [39:0] lat);
      cnt = ts;
      step(1, 0);
      idle_until(ts + lat);
      step(0, 1);
      repeat (5) step(0, 0);
   endtask

   task automatic user_clear();
      latency_reset_signal = 1'b1;
      step(0, 0);
      latency_reset_signal = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int rv_before;

   initial begin
      @(posedge clk);
      #1;
      cmp_start = cyc + 1;
      repeat (3) step(0, 0);
      rst = 1'b0;
      step(0, 0);
      check("reset_min", min_latency, 40'hFF_FFFF_FFFF);
      check("reset_outstanding", outstanding, 14'd0);
      check("reset_wea", bram_wea, 1'b0);

      echo(40'd100, 40'd250);
      check("single_last", last_latency, 40'd250);
      check("single_min", min_latency, 40'd250);
      check("single_max", max_latency, 40'd250);
      check("single_sum", sum_latency, 56'd250);
      check("single_num", num_samples, 32'd1);

      user_clear();
      echo(40'd1000, 40'd300);
      echo(40'd2000, 40'd120);
      echo(40'd3000, 40'd500);
      check("three_min", min_latency, 40'd120);
      check("three_max", max_latency, 40'd500);
      check("three_sum", sum_latency, 56'd920);
      check("three_num", num_samples, 32'd3);
      check("three_outstanding", outstanding, 14'd0);

      echo(40'hFF_FFFF_FFF0, 40'h20);
      check("wrap_last", last_latency, 40'h20);

      user_clear();
      step(1, 1);
      check("err_empty_same_cycle", err_empty, 1'b1);
      step(1, 0);
      rv_before = rv_cnt;
      step(0, 1);
      step(0, 0);
      step(0, 1);
      step(0, 0);
      step(0, 1);
      repeat (6) step(0, 0);
      check("err_overrun", err_overrun, 1'b1);
      check("overrun_results", rv_cnt - rv_before, 2);
      check("err_outstanding", outstanding, 14'd0);

      step(1, 0);
      step(0, 0);
      step(0, 1);
      step(0, 0);
      latency_reset_signal = 1'b1;
      step(0, 0);
      latency_reset_signal = 1'b0;
      check("clr_busy", rx_busy, 1'b0);
      check("clr_min", min_latency, 40'hFF_FFFF_FFFF);
      check("clr_num", num_samples, 32'd0);
      check("clr_errs", {err_full, err_empty, err_overrun}, 3'b000);
      repeat (4) step(0, 0);

      user_clear();
      for (int i = 0; i < 8192; i++) step(1, 0);
      check("full_outstanding", outstanding, 14'd8192);
      step(1, 0);
      check("full_drop_wea", bram_wea, 1'b0);
      check("err_full", err_full, 1'b1);
      step(0, 1);
      repeat (5) step(0, 0);
      step(1, 0);
      check("wrap_wea", bram_wea, 1'b1);
      check("wrap_addr", bram_wr_addr, 13'd0);
      check("wrap_outstanding", outstanding, 14'd8192);
      repeat (3) step(0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
